d_exec_stage: RTL and testbench

Execute-stage sequencer that sits directly upstream of the 8-bit ALU (`dALU`) and feeds it. It accepts one instruction at a time over a valid/ready handshake, reads operands from a private 4×8-bit register file, and drives the ALU's A, B and op inputs from registers. It then captures the ALU result and zero flag, writes the result back, and reports completion. It also executes load-immediate locally without using the ALU.

---
 rtl/d_exec_stage.sv | 138 +++++++++++++
 tb/tb_d_exec_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_exec_stage.sv
// Execute-stage sequencer feeding dALU: LDI runs locally, ALU ops issue registered operands.
// Latency: LDI/illegal complete 1 cycle after accept, ALU ops 2; instr_ready only in IDLE (no buffering).
module d_exec_stage #(
   parameter int NREGS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_op,
   input  logic [7:0]  alu_out,
   input  logic        alu_zero,
   output logic        res_valid,
   output logic [7:0]  res_data,
   output logic [1:0]  res_rd,
   output logic        zero_flag,
   output logic        err,
   input  logic [1:0]  dbg_sel,
   output logic [7:0]  dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXE} state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [7:0]  rf_q [NREGS];
   logic [7:0]  rf_d [NREGS];
   logic [7:0]  alu_a_q, alu_a_d;
   logic [7:0]  alu_b_q, alu_b_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic        res_valid_q, res_valid_d;
   logic [7:0]  res_data_q, res_data_d;
   logic [1:0]  res_rd_q, res_rd_d;
   logic        zero_q, zero_d;
   logic        err_q, err_d;

   logic [3:0]  op;
   logic [1:0]  rd, ra, rb;
   logic [7:0]  imm;

   assign op  = instr_q[15:12];
   assign rd  = instr_q[11:10];
   assign ra  = instr_q[9:8];
   assign rb  = instr_q[7:6];
   assign imm = instr_q[7:0];

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      rf_d        = rf_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      zero_d      = zero_q;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_DEC;
            end
         end
         S_DEC: begin
            state_d = S_IDLE;
            if (op == 4'd0) begin
               rf_d[rd]    = imm;
               zero_d      = (imm == 8'd0);
               res_data_d  = imm;
               res_rd_d    = rd;
               res_valid_d = 1'b1;
            end else if (!op[3]) begin
               // Operands sampled here, before the EXE write, so rd==ra/rb is safe.
               alu_a_d  = rf_q[ra];
               alu_b_d  = rf_q[rb];
               alu_op_d = op;
               state_d  = S_EXE;
            end else begin
               err_d = 1'b1;
            end
         end
         S_EXE: begin
            rf_d[rd]    = alu_out;
            zero_d      = alu_zero;
            res_data_d  = alu_out;
            res_rd_d    = rd;
            res_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         rf_q        <= '{default: '0};
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         rf_q        <= rf_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE) && !rst;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_rd      = res_rd_q;
   assign zero_flag   = zero_q;
   assign err         = err_q;
   assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_d_exec_stage.sv
// Bench for d_exec_stage: behavioural ALU stand-in plus an instruction-level reference model.
module tb_d_exec_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_zero;
   logic        res_valid, zero_flag, err;
   logic [7:0]  res_data, dbg_data;
   logic [1:0]  res_rd;
   logic [1:0]  dbg_sel = '0;

   int total = 0;
   int bad   = 0;

   // reference architectural state
   logic [7:0] m_rf [4];
   logic [7:0] m_alu_a, m_alu_b, m_res_data;
   logic [3:0] m_alu_op;
   logic [1:0] m_res_rd;
   logic       m_zero;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd1: return a | b;
         4'd2: return a & b;
         4'd3: return a ^ b;
         4'd4: return ~a;
         4'd5: return 8'((int'(a) + int'(b)) % 256);
         4'd6: return 8'((int'(a) * 2) % 256);
         4'd7: return b;
         default: return 8'd0;
      endcase
   endfunction

   assign alu_out  = alu_f(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_out == 8'd0);

   d_exec_stage #(.NREGS(4)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .zero_flag(zero_flag),
      .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
      return {op, rd, ra, rb, 6'd0};
   endfunction

   function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {4'd0, rd, 2'd0, imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
      m_alu_a = 0; m_alu_b = 0; m_alu_op = 0; m_res_data = 0; m_res_rd = 0; m_zero = 0;
   endtask

   // Issues one instruction, follows it to completion and checks every observable output.
   task automatic do_instr(input logic [15:0] w);
      logic [3:0] op;
      logic [1:0] rd, ra, rb, r;
      logic [7:0] res;
      int n;
      op = w[15:12]; rd = w[11:10]; ra = w[9:8]; rb = w[7:6];
      n = 0;
      while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (!instr_ready) begin bad++; $display("FAIL ready_timeout got=%0b exp=1", instr_ready); end
      instr = w; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = 16'($urandom);
      total++; if (res_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL pulse_width res_valid=%0b err=%0b exp=0/0", res_valid, err); end
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL ready_in_dec got=%0b exp=0", instr_ready); end
      @(posedge clk); #1;
      if (op == 4'd0) begin
         m_rf[rd] = w[7:0]; m_zero = (w[7:0] == 0); m_res_data = w[7:0]; m_res_rd = rd;
         total++; if (res_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL ldi_valid res_valid=%0b err=%0b exp=1/0", res_valid, err); end
      end else if (op < 4'd8) begin
         m_alu_a = m_rf[ra]; m_alu_b = m_rf[rb]; m_alu_op = op;
         total++; if (res_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL exe_quiet res_valid=%0b err=%0b exp=0/0", res_valid, err); end
         total++; if ({alu_a, alu_b, alu_op} !== {m_alu_a, m_alu_b, m_alu_op}) begin bad++; $display("FAIL alu_issue got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_op, m_alu_a, m_alu_b, m_alu_op); end
         total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL ready_in_exe got=%0b exp=0", instr_ready); end
         @(posedge clk); #1;
         res = alu_f(op, m_alu_a, m_alu_b);
         m_rf[rd] = res; m_zero = (res == 0); m_res_data = res; m_res_rd = rd;
         total++; if (res_valid !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL alu_valid res_valid=%0b err=%0b exp=1/0", res_valid, err); end
      end else begin
         total++; if (err !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL illegal err=%0b res_valid=%0b exp=1/0", err, res_valid); end
      end
      total++; if ({alu_a, alu_b, alu_op} !== {m_alu_a, m_alu_b, m_alu_op}) begin bad++; $display("FAIL alu_regs got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_op, m_alu_a, m_alu_b, m_alu_op); end
      total++; if (res_data !== m_res_data || res_rd !== m_res_rd) begin bad++; $display("FAIL res got=%h/r%0d exp=%h/r%0d", res_data, res_rd, m_res_data, m_res_rd); end
      total++; if (zero_flag !== m_zero) begin bad++; $display("FAIL zero_flag got=%0b exp=%0b", zero_flag, m_zero); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ready_after got=%0b exp=1", instr_ready); end
      dbg_sel = rd; #1;
      total++; if (dbg_data !== m_rf[rd]) begin bad++; $display("FAIL dbg_rd r%0d got=%h exp=%h", rd, dbg_data, m_rf[rd]); end
      r = 2'($urandom_range(0, 3)); dbg_sel = r; #1;
      total++; if (dbg_data !== m_rf[r]) begin bad++; $display("FAIL dbg_any r%0d got=%h exp=%h", r, dbg_data, m_rf[r]); end
   endtask

   task automatic test_reset();
      rst = 1'b1; model_reset();
      repeat (2) @(posedge clk); #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", instr_ready); end
      total++; if ({alu_a, alu_b, alu_op, res_valid, res_data, res_rd, zero_flag, err} !== 32'd0) begin bad++; $display("FAIL reset_outs got=%h/%h/%h/%0b/%h/%0d/%0b/%0b exp=all 0", alu_a, alu_b, alu_op, res_valid, res_data, res_rd, zero_flag, err); end
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i); #1;
         total++; if (dbg_data !== 8'd0) begin bad++; $display("FAIL reset_rf r%0d got=%h exp=00", i, dbg_data); end
      end
      rst = 1'b0; #1;
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b exp=1", instr_ready); end
   endtask

   task automatic test_ldi();
      do_instr(ldi(2'd1, 8'd2));
      total++; if (res_data !== 8'd2 || res_rd !== 2'd1 || zero_flag !== 1'b0) begin bad++; $display("FAIL ldi_const got=%h/r%0d/z%0b exp=02/r1/z0", res_data, res_rd, zero_flag); end
   endtask

   task automatic test_add();
      do_instr(ldi(2'd1, 8'd2)); do_instr(ldi(2'd2, 8'd3)); do_instr(enc(4'd5, 2'd3, 2'd1, 2'd2));
      dbg_sel = 2'd3; #1;
      total++; if (res_data !== 8'd5 || dbg_data !== 8'd5 || zero_flag !== 1'b0) begin bad++; $display("FAIL add_const got=%h rf3=%h z=%0b exp=05 05 0", res_data, dbg_data, zero_flag); end
   endtask

   task automatic test_and_wrap();
      do_instr(ldi(2'd1, 8'd2)); do_instr(ldi(2'd2, 8'd5)); do_instr(enc(4'd2, 2'd0, 2'd1, 2'd2));
      total++; if (res_data !== 8'd0 || zero_flag !== 1'b1) begin bad++; $display("FAIL and_zero got=%h z=%0b exp=00 1", res_data, zero_flag); end
      do_instr(ldi(2'd1, 8'd250)); do_instr(ldi(2'd2, 8'd7)); do_instr(enc(4'd5, 2'd1, 2'd1, 2'd2));
      dbg_sel = 2'd1; #1;
      total++; if (res_data !== 8'd1 || dbg_data !== 8'd1) begin bad++; $display("FAIL add_wrap got=%h rf1=%h exp=01 01", res_data, dbg_data); end
   endtask

   task automatic test_ldi_zero_shl();
      do_instr(ldi(2'd0, 8'd0));
      total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL ldi_zero got=%0b exp=1", zero_flag); end
      do_instr(ldi(2'd1, 8'd16)); do_instr(enc(4'd6, 2'd2, 2'd1, 2'd0));
      total++; if (res_data !== 8'd32) begin bad++; $display("FAIL shl got=%h exp=20", res_data); end
   endtask

   task automatic test_illegal();
      do_instr(enc(4'd9, 2'd3, 2'd1, 2'd2));
      do_instr(enc(4'd15, 2'd0, 2'd0, 2'd0));
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [3];
      int idx = 0;
      w[0] = enc(4'd5, 2'd3, 2'd3, 2'd1); w[1] = enc(4'd5, 2'd2, 2'd3, 2'd2); w[2] = enc(4'd5, 2'd1, 2'd1, 2'd2);
      instr_valid = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         logic acc;
         instr = (idx < 3) ? w[idx] : 16'hf000;
         instr_valid = (idx < 3);
         acc = instr_ready && instr_valid;
         @(posedge clk); #1;
         if (acc) begin
            total++; if (cyc != idx * 3) begin bad++; $display("FAIL b2b_accept idx=%0d cyc=%0d exp=%0d", idx, cyc, idx * 3); end
            m_alu_a = m_rf[w[idx][9:8]]; m_alu_b = m_rf[w[idx][7:6]]; m_alu_op = 4'd5;
            m_res_data = alu_f(4'd5, m_alu_a, m_alu_b); m_res_rd = w[idx][11:10];
            m_rf[m_res_rd] = m_res_data; m_zero = (m_res_data == 0);
            idx++;
         end
      end
      instr_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      total++; if (idx != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", idx); end
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i); #1;
         total++; if (dbg_data !== m_rf[i]) begin bad++; $display("FAIL b2b_rf r%0d got=%h exp=%h", i, dbg_data, m_rf[i]); end
      end
      total++; if (res_data !== m_res_data || zero_flag !== m_zero) begin bad++; $display("FAIL b2b_res got=%h z=%0b exp=%h z=%0b", res_data, zero_flag, m_res_data, m_zero); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w[15:12] = 4'd0;
         else if ($urandom_range(0, 5) != 0) w[15:12] = 4'($urandom_range(1, 7));
         do_instr(w);
      end
   endtask

   task automatic test_reset_mid();
      do_instr(ldi(2'd1, 8'd2)); do_instr(ldi(2'd2, 8'd3));
      instr = enc(4'd5, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
      @(posedge clk); #1; instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_rst got=%0b exp=0", instr_ready); end
      @(posedge clk); #1;
      model_reset();
      dbg_sel = 2'd3; #1;
      total++; if (res_valid !== 1'b0 || dbg_data !== 8'd0) begin bad++; $display("FAIL mid_discard res_valid=%0b rf3=%h exp=0 00", res_valid, dbg_data); end
      total++; if ({alu_a, alu_b, alu_op, res_data, zero_flag} !== 29'd0) begin bad++; $display("FAIL mid_outs got=%h/%h/%h/%h/%0b exp=all 0", alu_a, alu_b, alu_op, res_data, zero_flag); end
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL mid_release ready=%0b res_valid=%0b exp=1 0", instr_ready, res_valid); end
      do_instr(enc(4'd5, 2'd3, 2'd1, 2'd2));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_ldi();
      test_add();
      test_and_wrap();
      test_ldi_zero_shl();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
